// File: rtl/tx_queue.sv
// Store-and-forward transmit queue: buffers whole AXI4-Stream frames in a RAM FIFO and
// replays each one on the 10G MAC client TX interface only after its last beat is stored.
module tx_queue #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 9,
    parameter int MIN_GAP        = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AXI_DATA_WIDTH-1:0]   tdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] tstrb,
    input  logic                        tvalid,
    input  logic                        tlast,
    output logic                        tready,
    output logic [AXI_DATA_WIDTH-1:0]   tx_data,
    output logic [AXI_DATA_WIDTH/8-1:0] tx_data_valid,
    output logic                        tx_start,
    input  logic                        tx_ack,
    output logic                        tx_underrun,
    output logic                        drop_pkt,
    output logic                        strb_err
);

    localparam int DW    = AXI_DATA_WIDTH;
    localparam int SW    = AXI_DATA_WIDTH / 8;
    localparam int WW    = DW + SW + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

    logic [WW-1:0]    mem [DEPTH];
    logic [WW-1:0]    ram_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    wr_commit;
    logic [PW-1:0]    rd_ptr;
    logic             ready_en;
    logic             dropping;
    logic             full;
    logic             oversize;
    logic             accept;
    logic             store;
    logic [SW-1:0]    store_strb;

    state_t           state;
    logic             out_valid;
    logic [GAP_W-1:0] gap_cnt;
    logic             frame_avail;
    logic             gap_done;
    logic             launch;
    logic             advance;
    logic             rd_en;
    logic             ram_last;
    logic [SW-1:0]    ram_strb;
    logic [DW-1:0]    ram_data;

    assign ram_last    = ram_q[WW-1];
    assign ram_strb    = ram_q[DW +: SW];
    assign ram_data    = ram_q[DW-1:0];
    assign tx_underrun = 1'b0;

    // Write-side control. An oversize frame (FIFO full with nothing committed) keeps
    // tready high: the beat in flight is swallowed and the rest of the frame discarded.
    // NOTE: combinational blocks use blocking assignments with a default for every output, so no latches.
    always_comb begin
        full       = (wr_ptr - rd_ptr) == PW'(DEPTH);
        oversize   = full && (wr_commit == rd_ptr) && !dropping;
        tready     = ready_en && (!full || dropping || oversize);
        accept     = tvalid && tready;
        store      = accept && !dropping && !oversize;
        store_strb = '1;
        if (tlast)
            store_strb = (tstrb == '0) ? SW'(1) : tstrb;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            ready_en  <= 1'b0;
            dropping  <= 1'b0;
            drop_pkt  <= 1'b0;
            strb_err  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            drop_pkt <= 1'b0;
            strb_err <= store && tlast && (tstrb == '0);
            if (store) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (tlast)
                    wr_commit <= wr_ptr + PW'(1);
            end
            if (oversize) begin
                wr_ptr   <= wr_commit;
                dropping <= !(accept && tlast);
                drop_pkt <= accept && tlast;
            end else if (dropping && accept && tlast) begin
                dropping <= 1'b0;
                drop_pkt <= 1'b1;
            end
        end
    end

    // Read side: rd_ptr is the next address to fetch. ram_q only loads on rd_en, so it
    // holds word0 for as long as the MAC withholds tx_ack.
    always_comb begin
        frame_avail = wr_commit != rd_ptr;
        gap_done    = gap_cnt == GAP_W'(MIN_GAP - 1);
        launch      = frame_avail && ((state == IDLE) || (state == GAP && gap_done));
        advance     = !ram_last && ((state == START && tx_ack) || (state == SEND));
        rd_en       = launch || advance;
    end

    // NOTE: the frame storage has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {tlast, store_strb, tdata};
        if (rd_en)
            ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            tx_start  <= 1'b0;
            out_valid <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            if (rd_en)
                rd_ptr <= rd_ptr + PW'(1);
            case (state)
                IDLE, GAP: begin
                    if (launch) begin
                        state     <= START;
                        tx_start  <= 1'b1;
                        out_valid <= 1'b1;
                    end else if (state == GAP) begin
                        if (gap_done)
                            state <= IDLE;
                        else
                            gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                START: begin
                    if (tx_ack) begin
                        tx_start <= 1'b0;
                        if (ram_last) begin
                            state     <= GAP;
                            out_valid <= 1'b0;
                            gap_cnt   <= '0;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (ram_last) begin
                        state     <= GAP;
                        out_valid <= 1'b0;
                        gap_cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The RAM output register feeds the MAC directly; the registered valid forces zeros
    // when idle and clears the bus the instant reset asserts.
    assign tx_data       = out_valid ? ram_data : '0;
    assign tx_data_valid = out_valid ? ram_strb : '0;

endmodule
